// File: rtl/bus_initiator.sv
// bus_initiator: master end of the shared 8-bit peripheral bus.
// A local client queues read/write requests into a small FIFO. A state
// machine then runs each request as one or more bus cycles against
// register-mapped responders.
//
// Ports:
//   CLK, RESET        clock and synchronous active-high reset
//   REQ_VALID/READY   client request handshake (READY is combinational)
//   REQ_WE/ADDR/DATA  request: 1 = write, target address, write data
//   RD_VALID/RD_DATA  one-cycle read-complete pulse; the data is held until
//                     the next read completes
//   BUSY              FIFO non-empty or bus cycle in progress
//   BUS_DATA          tri-state data; driven only while a write cycle runs
//   BUS_ADDR/BUS_WE   registered bus address and write strobe
module bus_initiator #(
  parameter logic [7:0] IDLE_ADDR  = 8'hFF,
  parameter int         FIFO_DEPTH = 4,
  parameter int         FIFO_AW    = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_WE,
  input  logic [7:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  output logic       RD_VALID,
  output logic [7:0] RD_DATA,
  output logic       BUSY,
  inout  wire  [7:0] BUS_DATA,
  output logic [7:0] BUS_ADDR,
  output logic       BUS_WE
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_RD_A  = 3'd2,
    ST_RD_S  = 3'd3,
    ST_TURN  = 3'd4
  } state_t;

  localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

  // FIFO entry layout: {we, addr[7:0], data[7:0]}
  logic [16:0]      fifo_mem_q [FIFO_DEPTH];
  logic [FIFO_AW:0] wptr_q;
  logic [FIFO_AW:0] rptr_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             do_push;
  logic             do_pop;
  logic             pop_ok;
  logic [16:0]      fifo_head;

  state_t     state_q;
  logic [7:0] addr_q;
  logic       we_q;
  logic [7:0] wdata_q;
  logic       drive_q;
  logic       rd_valid_q;
  logic [7:0] rd_data_q;

  // The pointers carry one extra wrap bit: equal index with different wrap
  // bits means full, and fully equal pointers mean empty.
  assign fifo_full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                      (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_head  = fifo_mem_q[rptr_q[FIFO_AW-1:0]];

  assign REQ_READY = !fifo_full && !RESET;
  assign do_push   = REQ_VALID && REQ_READY;

  // A new command may start only from states that free the bus at this edge.
  assign pop_ok = (state_q == ST_IDLE) || (state_q == ST_WRITE) || (state_q == ST_TURN);
  assign do_pop = !fifo_empty && pop_ok;

  assign BUS_ADDR = addr_q;
  assign BUS_WE   = we_q;
  assign BUS_DATA = drive_q ? wdata_q : 8'hZZ;
  assign RD_VALID = rd_valid_q;
  assign RD_DATA  = rd_data_q;
  assign BUSY     = !fifo_empty || (state_q != ST_IDLE);

  // Request FIFO storage and pointers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) begin
        fifo_mem_q[wptr_q[FIFO_AW-1:0]] <= {REQ_WE, REQ_ADDR, REQ_DATA};
        wptr_q <= wptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
    end
  end

  // Bus cycle state machine with registered bus and read-result outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      addr_q     <= IDLE_ADDR;
      we_q       <= 1'b0;
      wdata_q    <= 8'h00;
      drive_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_WRITE, ST_TURN: begin
          if (do_pop) begin
            addr_q  <= fifo_head[15:8];
            wdata_q <= fifo_head[7:0];
            if (fifo_head[16]) begin
              state_q <= ST_WRITE;
              we_q    <= 1'b1;
              drive_q <= 1'b1;
            end else begin
              state_q <= ST_RD_A;
              we_q    <= 1'b0;
              drive_q <= 1'b0;
            end
          end else begin
            state_q <= ST_IDLE;
            addr_q  <= IDLE_ADDR;
            we_q    <= 1'b0;
            drive_q <= 1'b0;
          end
        end
        ST_RD_A: begin
          // Responder registers its output at the end of this cycle.
          state_q <= ST_RD_S;
        end
        ST_RD_S: begin
          // The address is parked during TURN while the responder still drives.
          state_q    <= ST_TURN;
          addr_q     <= IDLE_ADDR;
          rd_data_q  <= BUS_DATA;
          rd_valid_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          addr_q  <= IDLE_ADDR;
          we_q    <= 1'b0;
          drive_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator. It contains a reactive responder that is mapped at
// 0xD0/0xD1 and a keeper that drives 0xA5 whenever neither agent should drive
// the bus. It also contains a transaction-level model: a request queue plus a
// queue of expected bus cycles per command.
module tb_bus_initiator;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_WE;
  logic [7:0] REQ_ADDR;
  logic [7:0] REQ_DATA;
  logic       RD_VALID;
  logic [7:0] RD_DATA;
  logic       BUSY;
  wire  [7:0] bus_data;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;

  int n_cmp  = 0;
  int n_fail = 0;
  logic cmp_en = 1'b0;

  always #5 CLK = ~CLK;

  bus_initiator dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .BUSY(BUSY),
    .BUS_DATA(bus_data), .BUS_ADDR(BUS_ADDR), .BUS_WE(BUS_WE)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- responder + keeper ----------------
  function automatic logic mapped(input logic [7:0] a);
    return (a == 8'hD0) || (a == 8'hD1);
  endfunction

  logic [7:0] resp_reg [2];
  logic       resp_drv_q;
  logic [7:0] resp_dat_q;

  always @(posedge CLK) begin
    if (RESET) begin
      resp_reg[0] <= 8'h00;
      resp_reg[1] <= 8'h5A;
      resp_drv_q  <= 1'b0;
    end else begin
      if (BUS_WE && mapped(BUS_ADDR)) resp_reg[BUS_ADDR[0]] <= bus_data;
      resp_drv_q <= !BUS_WE && mapped(BUS_ADDR);
    end
    resp_dat_q <= resp_reg[BUS_ADDR[0]];
  end

  typedef struct packed {
    logic       act;
    logic [7:0] addr;
    logic       we;
    logic [7:0] bus;
    logic       rdv;
  } cyc_t;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } req_t;

  cyc_t exp_cur;
  logic env_en;
  logic [7:0] env_val;

  always_comb begin
    env_en  = 1'b1;
    env_val = 8'hA5;
    if (resp_drv_q) env_val = resp_dat_q;
    else if (exp_cur.we) env_en = 1'b0;
  end
  assign bus_data = env_en ? env_val : 8'hZZ;

  // ---------------- transaction-level model ----------------
  req_t mfifo[$];
  cyc_t sched[$];
  logic [7:0] exp_rd = 8'h00;
  logic [7:0] mregs [2];

  function automatic cyc_t mk(input logic act, input logic [7:0] a, input logic we,
                              input logic [7:0] b, input logic rdv);
    return {act, a, we, b, rdv};
  endfunction

  always @(posedge CLK) begin : model_b
    req_t r;
    cyc_t c;
    logic acc;
    logic [7:0] d;
    acc = REQ_VALID && !RESET && (mfifo.size() < 4);
    c = mk(1'b0, 8'hFF, 1'b0, 8'hA5, 1'b0);
    if (RESET) begin
      mfifo.delete();
      sched.delete();
      exp_rd   = 8'h00;
      mregs[0] = 8'h00;
      mregs[1] = 8'h5A;
    end else begin
      if (sched.size() == 0 && mfifo.size() != 0) begin
        r = mfifo.pop_front();
        if (r.we) begin
          sched.push_back(mk(1'b1, r.addr, 1'b1, r.data, 1'b0));
          if (mapped(r.addr)) mregs[r.addr[0]] = r.data;
        end else begin
          d = mregs[r.addr[0]];
          sched.push_back(mk(1'b1, r.addr, 1'b0, 8'hA5, 1'b0));
          sched.push_back(mk(1'b1, r.addr, 1'b0, d, 1'b0));
          sched.push_back(mk(1'b1, 8'hFF, 1'b0, d, 1'b1));
        end
      end
      if (sched.size() != 0) c = sched.pop_front();
      if (c.rdv) exp_rd = c.bus;
      if (acc) mfifo.push_back({REQ_WE, REQ_ADDR, REQ_DATA});
    end
    exp_cur <= c;
  end

  // ---------------- monitors and per-cycle compare ----------------
  int rdv_total = 0;
  int we_run = 0;
  int we_run_max = 0;

  always @(negedge CLK) begin
    if (RD_VALID) rdv_total++;
    if (BUS_WE) we_run++;
    else we_run = 0;
    if (we_run > we_run_max) we_run_max = we_run;
    if (cmp_en) begin
      chk("bus_addr", BUS_ADDR, exp_cur.addr);
      chk("bus_we", BUS_WE, exp_cur.we);
      chk("bus_data", bus_data, exp_cur.bus);
      chk("rd_valid", RD_VALID, exp_cur.rdv);
      chk("rd_data", RD_DATA, exp_rd);
      chk("busy", BUSY, (mfifo.size() != 0) || exp_cur.act);
      chk("req_ready", REQ_READY, (mfifo.size() < 4) && !RESET);
      chk("contention", BUS_WE & resp_drv_q, 1'b0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic push(input logic we, input logic [7:0] a, input logic [7:0] d,
                      output int stalls);
    logic acc;
    acc = 1'b0;
    stalls = 0;
    REQ_VALID = 1'b1;
    REQ_WE = we;
    REQ_ADDR = a;
    REQ_DATA = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      acc = REQ_READY;
      tick();
      if (acc) break;
      stalls++;
    end
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!BUSY) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin : timeout_b
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim_b
    int st;
    int st3;
    int st4;
    int snap;
    RESET = 1'b1;
    REQ_VALID = 1'b0;
    REQ_WE = 1'b0;
    REQ_ADDR = 8'h00;
    REQ_DATA = 8'h00;

    // 1: reset held two cycles
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst_addr", BUS_ADDR, 8'hFF);
    chk("rst_we", BUS_WE, 1'b0);
    chk("rst_ready", REQ_READY, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    RESET = 1'b0;
    #1;
    chk("ready_after_rst", REQ_READY, 1'b1);

    // 2: single write D0 <- 3C, bus one cycle later
    push(1'b1, 8'hD0, 8'h3C, st);
    tick();
    chk("wr_addr", BUS_ADDR, 8'hD0);
    chk("wr_we", BUS_WE, 1'b1);
    chk("wr_data", bus_data, 8'h3C);
    tick();
    chk("wr_end_addr", BUS_ADDR, 8'hFF);
    chk("wr_end_we", BUS_WE, 1'b0);
    wait_idle();
    chk("resp_d0", resp_reg[0], 8'h3C);

    // 3: read D1 (holds 5A): RD_A, RD_S, then TURN with RD_VALID
    push(1'b0, 8'hD1, 8'h00, st);
    tick();
    chk("rda_addr", BUS_ADDR, 8'hD1);
    tick();
    chk("rds_addr", BUS_ADDR, 8'hD1);
    tick();
    chk("turn_addr", BUS_ADDR, 8'hFF);
    chk("turn_rdv", RD_VALID, 1'b1);
    chk("turn_rdata", RD_DATA, 8'h5A);
    wait_idle();

    // 4: three reads hold the bus while five writes fill the FIFO
    for (int i = 0; i < 3; i++) push(1'b0, 8'hD1, 8'h00, st);
    push(1'b1, 8'hD0, 8'h11, st);
    push(1'b1, 8'hD1, 8'h22, st);
    push(1'b1, 8'hD0, 8'h33, st);
    push(1'b1, 8'hD1, 8'h44, st3);
    push(1'b1, 8'hD0, 8'h55, st4);
    chk("w3_stalls", st3, 32'd2);
    chk("w4_stalls", st4, 32'd2);
    wait_idle();
    chk("we_run_5", we_run_max, 32'd5);
    chk("rd_after_burst", RD_DATA, 8'h5A);

    // 5: read D0, then write D1 <- 77 and a write to the idle address
    push(1'b0, 8'hD0, 8'h00, st);
    push(1'b1, 8'hD1, 8'h77, st);
    push(1'b1, 8'hFF, 8'h99, st);
    wait_idle();
    chk("rd_d0", RD_DATA, 8'h55);
    chk("resp_d1", resp_reg[1], 8'h77);

    // 6: reset asserted while the read is in RD_S
    snap = rdv_total;
    push(1'b0, 8'hD1, 8'h00, st);
    tick();
    tick();
    chk("pre_rst_rds", BUS_ADDR, 8'hD1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("abort_addr", BUS_ADDR, 8'hFF);
    chk("abort_rdv", RD_VALID, 1'b0);
    chk("abort_rdata", RD_DATA, 8'h00);
    chk("abort_busy", BUSY, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("abort_no_pulse", rdv_total, snap);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
